// File: rtl/ctrl_menu_keys.sv
`default_nettype none
// ============================================================================
// ctrl_menu_keys : controller poll words -> menu key events (press + auto-repeat)
// Rev 1.0
// ============================================================================
module ctrl_menu_keys #(
  parameter logic signed [7:0] STICK_TH        = 8'sd48,
  parameter logic [5:0]        REPEAT_DELAY    = 6'd20,
  parameter logic [5:0]        REPEAT_RATE     = 6'd5,
  parameter logic [19:0]       TIMEOUT_CYCLES  = 20'hFFFFF,
  parameter int                FIFO_DEPTH_LOG2 = 2
) (
  input  logic        CTRL_CLK,
  input  logic        CTRL_nRST,
  input  logic [31:0] ctrl_data_i,
  input  logic        ctrl_valid_i,
  input  logic        enable_i,
  input  logic        evt_rd_i,
  output logic [3:0]  evt_code_o,
  output logic        evt_empty_o,
  output logic        evt_ovf_o,
  output logic [3:0]  key_held_o
);

  localparam int             PW       = FIFO_DEPTH_LOG2;
  localparam int             CW       = FIFO_DEPTH_LOG2 + 1;
  localparam int             DEPTH    = 1 << FIFO_DEPTH_LOG2;
  localparam logic [PW-1:0]  PTR_ONE  = PW'(1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    HELD_DELAY  = 2'd1,
    HELD_REPEAT = 2'd2
  } key_state_t;

  key_state_t state;
  logic [5:0]  rpt_cnt;
  logic [19:0] tmo_cnt;

  logic signed [7:0] axis_x, axis_y;
  logic signed [7:0] neg_th;
  logic [3:0]        key_code;
  logic              code_changed, repeatable, repeat_fire, key_push, timeout_hit;
  logic              unused_bits;

  assign unused_bits = ^{ctrl_data_i[9:8], ctrl_data_i[2]};
  assign neg_th      = -STICK_TH;

  // Axis bytes arrive LSB-first from the sniffer, so bit 16/24 is the MSB
  always_comb begin
    axis_x = '0;
    axis_y = '0;
    for (int i = 0; i < 8; i++) begin
      axis_x[7-i] = ctrl_data_i[16+i];
      axis_y[7-i] = ctrl_data_i[24+i];
    end
  end

  always_comb begin
    key_code = 4'h0;
    if (ctrl_data_i[10] && ctrl_data_i[11] && ctrl_data_i[7])
      key_code = 4'h8;
    else if (ctrl_data_i[3])
      key_code = 4'h7;
    else if (ctrl_data_i[0])
      key_code = 4'h5;
    else if (ctrl_data_i[1])
      key_code = 4'h6;
    else if (ctrl_data_i[4] || ctrl_data_i[12] || (axis_y >= STICK_TH))
      key_code = 4'h1;
    else if (ctrl_data_i[5] || ctrl_data_i[13] || (axis_y <= neg_th))
      key_code = 4'h2;
    else if (ctrl_data_i[6] || ctrl_data_i[14] || (axis_x <= neg_th))
      key_code = 4'h3;
    else if (ctrl_data_i[7] || ctrl_data_i[15] || (axis_x >= STICK_TH))
      key_code = 4'h4;
  end

  always_comb begin
    code_changed = (key_code != key_held_o);
    repeatable   = (key_code >= 4'h1) && (key_code <= 4'h4);
    repeat_fire  = repeatable && !code_changed && (rpt_cnt == 6'd1) && (state != IDLE);
    key_push     = ctrl_valid_i && (key_code != 4'h0) && (code_changed || repeat_fire);
    timeout_hit  = !ctrl_valid_i && (tmo_cnt >= (TIMEOUT_CYCLES - 20'd1));
  end

  always_ff @(posedge CTRL_CLK or negedge CTRL_nRST) begin
    if (!CTRL_nRST) begin
      state      <= IDLE;
      key_held_o <= 4'h0;
      rpt_cnt    <= 6'd0;
      tmo_cnt    <= 20'd0;
    end else begin
      if (ctrl_valid_i) begin
        tmo_cnt    <= 20'd0;
        key_held_o <= key_code;
        case (state)
          IDLE: begin
            if (key_code != 4'h0) begin
              state   <= HELD_DELAY;
              rpt_cnt <= REPEAT_DELAY;
            end
          end
          default: begin
            if (key_code == 4'h0) begin
              state   <= IDLE;
              rpt_cnt <= 6'd0;
            end else if (code_changed) begin
              state   <= HELD_DELAY;
              rpt_cnt <= REPEAT_DELAY;
            end else if (repeat_fire) begin
              state   <= HELD_REPEAT;
              rpt_cnt <= REPEAT_RATE;
            end else if (rpt_cnt > 6'd1) begin
              rpt_cnt <= rpt_cnt - 6'd1;
            end
          end
        endcase
      end else begin
        if (tmo_cnt != TIMEOUT_CYCLES)
          tmo_cnt <= tmo_cnt + 20'd1;
        // A silent controller must not leave a key stuck down forever
        if (timeout_hit) begin
          state      <= IDLE;
          key_held_o <= 4'h0;
          rpt_cnt    <= 6'd0;
        end
      end
    end
  end

  logic [3:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, next_rd;
  logic [CW-1:0] count, next_count;
  logic          fifo_full, push_req, do_push, do_pop, ovf_set;
  logic [3:0]    head_next;

  always_comb begin
    fifo_full  = (count == CNT_FULL);
    push_req   = key_push && enable_i;
    do_pop     = evt_rd_i && enable_i && (count != '0);
    do_push    = push_req && (!fifo_full || do_pop);
    ovf_set    = push_req && fifo_full && !do_pop;
    next_rd    = do_pop ? (rd_ptr + PTR_ONE) : rd_ptr;
    next_count = count;
    if (do_push && !do_pop)
      next_count = count + CNT_ONE;
    else if (do_pop && !do_push)
      next_count = count - CNT_ONE;
    // The entry being written this cycle may become the new head
    head_next = (do_push && (next_rd == wr_ptr)) ? key_code : mem[next_rd];
  end

  always_ff @(posedge CTRL_CLK) begin
    if (do_push)
      mem[wr_ptr] <= key_code;
  end

  always_ff @(posedge CTRL_CLK or negedge CTRL_nRST) begin
    if (!CTRL_nRST) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      evt_code_o  <= 4'h0;
      evt_empty_o <= 1'b1;
      evt_ovf_o   <= 1'b0;
    end else if (!enable_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      evt_code_o  <= 4'h0;
      evt_empty_o <= 1'b1;
      evt_ovf_o   <= 1'b0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + PTR_ONE;
      rd_ptr <= next_rd;
      count  <= next_count;
      if (do_pop)
        evt_ovf_o <= 1'b0;
      else if (ovf_set)
        evt_ovf_o <= 1'b1;
      evt_code_o  <= (next_count == '0) ? 4'h0 : head_next;
      evt_empty_o <= (next_count == '0);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ctrl_menu_keys.sv
`default_nettype none
// ============================================================================
// tb_ctrl_menu_keys : scoreboard bench for ctrl_menu_keys
// Rev 1.0
// ============================================================================
module tb_ctrl_menu_keys;

  localparam logic [19:0] TMO = 20'd300;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data;
  logic        valid, enable, rd;
  logic [3:0]  evt_code, key_held;
  logic        evt_empty, evt_ovf;

  int          errors = 0;
  int          checks = 0;
  logic [3:0]  q[$];
  logic        exp_ovf = 1'b0;

  ctrl_menu_keys #(
    .STICK_TH(8'sd48), .REPEAT_DELAY(6'd20), .REPEAT_RATE(6'd5),
    .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH_LOG2(2)
  ) dut (
    .CTRL_CLK(clk), .CTRL_nRST(rst_n), .ctrl_data_i(data), .ctrl_valid_i(valid),
    .enable_i(enable), .evt_rd_i(rd), .evt_code_o(evt_code), .evt_empty_o(evt_empty),
    .evt_ovf_o(evt_ovf), .key_held_o(key_held)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = v[i];
    return r;
  endfunction

  task automatic exp_push(input logic [3:0] code);
    if (q.size() < 4) q.push_back(code);
    else exp_ovf = 1'b1;
  endtask

  task automatic poll(input logic [31:0] d);
    @(negedge clk);
    data  = d;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic read_one(input string name);
    logic [3:0] exp;
    @(negedge clk);
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, evt_code=%h empty=%b", name, evt_code, evt_empty);
    end else begin
      exp = q.pop_front();
      if (evt_code !== exp || evt_empty !== 1'b0) begin
        errors++;
        $display("FAIL %s: evt_code=%h empty=%b, expected code=%h empty=0", name, evt_code, evt_empty, exp);
      end
    end
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    exp_ovf = 1'b0;
  endtask

  task automatic check_held(input string name, input logic [3:0] exp);
    checks++;
    if (key_held !== exp) begin
      errors++;
      $display("FAIL %s: key_held=%h, expected %h", name, key_held, exp);
    end
  endtask

  task automatic check_fifo(input string name);
    checks++;
    if (evt_empty !== (q.size() == 0) || evt_ovf !== exp_ovf) begin
      errors++;
      $display("FAIL %s: empty=%b ovf=%b, expected empty=%b ovf=%b",
               name, evt_empty, evt_ovf, (q.size() == 0), exp_ovf);
    end
  endtask

  task automatic drain(input string name);
    while (q.size() > 0) read_one(name);
    @(negedge clk);
    check_fifo({name, "_empty"});
  endtask

  task automatic test_reset;
    rst_n = 1'b0; data = '0; valid = 1'b0; enable = 1'b1; rd = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (evt_code !== 4'h0 || evt_empty !== 1'b1 || evt_ovf !== 1'b0 || key_held !== 4'h0) begin
      errors++;
      $display("FAIL reset: code=%h empty=%b ovf=%b held=%h, expected 0 1 0 0",
               evt_code, evt_empty, evt_ovf, key_held);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_press;
    poll(32'h0000_0001);
    exp_push(4'h5);
    check_held("single_held_a", 4'h5);
    poll(32'h0);
    check_held("single_release", 4'h0);
    checks++;
    if (evt_code !== 4'h5) begin
      errors++;
      $display("FAIL single_head: evt_code=%h, expected 5", evt_code);
    end
    check_fifo("single_fifo");
  endtask

  // Leaves the single A event queued, so the fifth push overflows
  task automatic test_repeat;
    for (int p = 1; p <= 32; p++) begin
      poll(32'h0000_0010);
      if (p == 1 || (p >= 21 && ((p - 21) % 5) == 0)) exp_push(4'h1);
    end
    check_held("repeat_held", 4'h1);
    check_fifo("repeat_overflow");
    read_one("repeat_first_read");
    @(negedge clk);
    check_fifo("repeat_ovf_cleared");
    checks++;
    if (evt_code !== 4'h1) begin
      errors++;
      $display("FAIL repeat_next_head: evt_code=%h, expected 1", evt_code);
    end
    poll(32'h0);
    drain("repeat_drain");
  endtask

  task automatic test_stick;
    logic [7:0] val [7] = '{8'd60, 8'd40, 8'd47, 8'd48, 8'hD0, 8'hD1, 8'hD0};
    logic       isx [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0] exp [7] = '{4'h1, 4'h0, 4'h0, 4'h1, 4'h2, 4'h0, 4'h3};
    for (int i = 0; i < 7; i++) begin
      poll(isx[i] ? {8'h00, rev8(val[i]), 16'h0} : {rev8(val[i]), 24'h0});
      check_held($sformatf("stick_%0d", i), exp[i]);
      if (exp[i] != 4'h0) exp_push(exp[i]);
      poll(32'h0);
      if (q.size() > 0) read_one($sformatf("stick_evt_%0d", i));
    end
    drain("stick_drain");
  endtask

  task automatic test_menu;
    for (int p = 0; p < 40; p++) poll(32'h0000_0C80);
    exp_push(4'h8);
    check_held("menu_held", 4'h8);
    poll(32'h0);
    drain("menu_drain");
  endtask

  task automatic test_timeout;
    poll(32'h0000_0020);
    exp_push(4'h2);
    repeat (int'(TMO) - 10) @(negedge clk);
    check_held("timeout_before", 4'h2);
    repeat (11) @(negedge clk);
    check_held("timeout_after", 4'h0);
    poll(32'h0000_0020);
    exp_push(4'h2);
    check_held("timeout_resume", 4'h2);
    poll(32'h0);
    drain("timeout_drain");
  endtask

  task automatic test_back_to_back;
    logic [31:0] keys [4] = '{32'h01, 32'h02, 32'h08, 32'h10};
    logic [3:0]  codes[4] = '{4'h5, 4'h6, 4'h7, 4'h1};
    for (int i = 0; i < 4; i++) begin
      poll(keys[i]);
      exp_push(codes[i]);
      poll(32'h0);
    end
    @(negedge clk);
    checks++;
    if (evt_code !== q[0]) begin
      errors++;
      $display("FAIL b2b_head: evt_code=%h, expected %h", evt_code, q[0]);
    end
    void'(q.pop_front());
    data = 32'h0000_0020; valid = 1'b1; rd = 1'b1;
    exp_push(4'h2);
    @(negedge clk);
    valid = 1'b0; rd = 1'b0;
    check_fifo("b2b_no_ovf");
    poll(32'h0);
    drain("b2b_drain");
  endtask

  task automatic test_enable;
    poll(32'h0000_0040);
    exp_push(4'h3);
    @(negedge clk);
    enable = 1'b0;
    q.delete();
    exp_ovf = 1'b0;
    @(negedge clk);
    check_fifo("enable_flush");
    poll(32'h0000_0080);
    check_held("enable_tracked", 4'h4);
    check_fifo("enable_no_push");
    enable = 1'b1;
    poll(32'h0000_0080);
    @(negedge clk);
    check_fifo("enable_no_spurious");
    poll(32'h0);
  endtask

  task automatic test_reset_mid;
    for (int p = 0; p < 25; p++) poll(32'h0000_0010);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (evt_code !== 4'h0 || evt_empty !== 1'b1 || evt_ovf !== 1'b0 || key_held !== 4'h0) begin
      errors++;
      $display("FAIL reset_mid: code=%h empty=%b ovf=%b held=%h, expected 0 1 0 0",
               evt_code, evt_empty, evt_ovf, key_held);
    end
    q.delete();
    exp_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    poll(32'h0000_0001);
    exp_push(4'h5);
    poll(32'h0);
    drain("reset_mid_recover");
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_repeat();
    test_stick();
    test_menu();
    test_timeout();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
